// File: rtl/uart_tx_feeder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_feeder_pkg
// Description : Shared constants for the UART transmit feeder: FSM state
//               encodings and default sizing parameters.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_tx_feeder_pkg;

    localparam int DEF_DEPTH = 16;
    localparam int DEF_CNT_W = 16;
    localparam int BYTE_W    = 8;

    // Two-state issue FSM
    localparam logic [0:0] IDLE      = 1'b0;
    localparam logic [0:0] WAIT_DONE = 1'b1;

endpackage
`default_nettype wire

// File: rtl/uart_byte_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_byte_fifo
// Description : Byte FIFO with registered pointers, combinational head read,
//               occupancy count and a sticky overflow flag. Writes while full
//               are dropped even if a pop happens in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_byte_fifo
    import uart_tx_feeder_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                      clk,
    input  logic                      Reset,
    input  logic                      wr_en,
    input  logic [BYTE_W-1:0]         wr_data,
    input  logic                      rd_en,
    output logic [BYTE_W-1:0]         rd_data,
    output logic                      full,
    output logic                      empty,
    output logic [$clog2(DEPTH):0]    level,
    output logic                      overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [BYTE_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;
    logic              push_ok;
    logic              pop_ok;

    // Flags come from the pre-edge occupancy; a full FIFO never accepts
    assign full    = (count == FULL_LVL);
    assign empty   = (count == '0);
    assign level   = count;
    assign rd_data = mem[rd_ptr];
    assign push_ok = wr_en && !full;
    assign pop_ok  = rd_en && !empty;

    // Pointer, occupancy and overflow bookkeeping; pointers wrap naturally
    always_ff @(posedge clk) begin
        if (Reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
            if (wr_en && full) overflow <= 1'b1;
        end
    end

    // Storage array; contents need no reset since pointers gate visibility
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= wr_data;
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_feeder.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_feeder
// Description : Queues bytes in a FIFO and hands them one at a time to a UART
//               transmitter with a registered start pulse, waiting for the
//               transmitter's completion pulse before issuing the next byte.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_feeder
    import uart_tx_feeder_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic                      clk,
    input  logic                      Reset,
    input  logic                      Wr_En,
    input  logic [BYTE_W-1:0]         Wr_Data,
    output logic                      Full,
    output logic                      Empty,
    output logic [$clog2(DEPTH):0]    Level,
    output logic                      Overflow,
    input  logic                      Tx_Ready,
    input  logic                      Tx_Complete,
    output logic                      Tx_Enable,
    output logic [BYTE_W-1:0]         Tx_Data,
    output logic                      Busy,
    output logic [CNT_W-1:0]          Sent_Count
);

    logic [0:0]        state;
    logic [0:0]        next_state;
    logic              issue;
    logic              done;
    logic [BYTE_W-1:0] head;

    uart_byte_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .Reset    (Reset),
        .wr_en    (Wr_En),
        .wr_data  (Wr_Data),
        .rd_en    (issue),
        .rd_data  (head),
        .full     (Full),
        .empty    (Empty),
        .level    (Level),
        .overflow (Overflow)
    );

    // State register
    always_ff @(posedge clk) begin
        if (Reset) state <= IDLE;
        else       state <= next_state;
    end

    // Next-state logic: Tx_Ready only matters in IDLE, Tx_Complete only in WAIT_DONE
    always_comb begin
        next_state = state;
        case (state)
            IDLE:      if (!Empty && Tx_Ready) next_state = WAIT_DONE;
            WAIT_DONE: if (Tx_Complete)        next_state = IDLE;
            default:   next_state = IDLE;
        endcase
    end

    // Output decode: pop/issue strobe and completion strobe
    always_comb begin
        issue = 1'b0;
        done  = 1'b0;
        case (state)
            IDLE:      issue = !Empty && Tx_Ready;
            WAIT_DONE: done  = Tx_Complete;
            default: begin
                issue = 1'b0;
                done  = 1'b0;
            end
        endcase
    end

    assign Busy = (state == WAIT_DONE);

    // Registered transmitter interface and completed-byte counter
    always_ff @(posedge clk) begin
        if (Reset) begin
            Tx_Enable  <= 1'b0;
            Tx_Data    <= '0;
            Sent_Count <= '0;
        end else begin
            Tx_Enable <= issue;
            if (issue) Tx_Data    <= head;
            if (done)  Sent_Count <= Sent_Count + CNT_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_feeder.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_feeder
// Description : Self-checking bench for uart_tx_feeder with a bit-serial
//               transmitter model (4 clocks per bit) and a byte scoreboard.
//               A second instance with a 4-bit counter shares all stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_feeder;

    logic        clk = 1'b0;
    logic        Reset;
    logic        Wr_En;
    logic [7:0]  Wr_Data;
    logic        Full, Empty, Overflow, Tx_Enable, Busy;
    logic [4:0]  Level;
    logic [7:0]  Tx_Data;
    logic [15:0] Sent_Count;
    logic        Tx_Ready, Tx_Complete;

    logic        b_full, b_empty, b_ovf, b_en, b_busy;
    logic [4:0]  b_level;
    logic [7:0]  b_data;
    logic [3:0]  b_count;

    logic        hold;
    logic        tx_idle;
    logic        ser;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] exp_q[$];
    logic [7:0] frame_q[$];

    always #5 clk = ~clk;

    assign Tx_Ready = tx_idle & ~hold;

    uart_tx_feeder #(.DEPTH(16), .CNT_W(16)) dut (
        .clk(clk), .Reset(Reset), .Wr_En(Wr_En), .Wr_Data(Wr_Data),
        .Full(Full), .Empty(Empty), .Level(Level), .Overflow(Overflow),
        .Tx_Ready(Tx_Ready), .Tx_Complete(Tx_Complete), .Tx_Enable(Tx_Enable),
        .Tx_Data(Tx_Data), .Busy(Busy), .Sent_Count(Sent_Count)
    );

    uart_tx_feeder #(.DEPTH(16), .CNT_W(4)) dut_w4 (
        .clk(clk), .Reset(Reset), .Wr_En(Wr_En), .Wr_Data(Wr_Data),
        .Full(b_full), .Empty(b_empty), .Level(b_level), .Overflow(b_ovf),
        .Tx_Ready(Tx_Ready), .Tx_Complete(Tx_Complete), .Tx_Enable(b_en),
        .Tx_Data(b_data), .Busy(b_busy), .Sent_Count(b_count)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Transmitter model: acts just after each rising edge
    // ------------------------------------------------------------------
    logic [7:0] m_b;
    logic [9:0] m_bits, m_frame, last_frame;
    logic       m_stable, m_rst_seen;
    logic [7:0] m_e;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bit_tick();
        tick();
        if (Reset) m_rst_seen = 1'b1;
        if (!m_rst_seen && Tx_Data !== m_b) m_stable = 1'b0;
    endtask

    initial begin
        tx_idle     = 1'b1;
        Tx_Complete = 1'b0;
        ser         = 1'b1;
        last_frame  = '0;
        forever begin
            tick();
            if (Tx_Enable) begin
                m_b        = Tx_Data;
                tx_idle    = 1'b0;
                m_stable   = 1'b1;
                m_rst_seen = 1'b0;
                m_bits     = {1'b1, m_b, 1'b0};
                for (int i = 0; i < 10; i++) begin
                    ser = m_bits[i];
                    repeat (2) bit_tick();
                    m_frame[i] = ser;
                    repeat (2) bit_tick();
                end
                ser         = 1'b1;
                Tx_Complete = 1'b1;
                tx_idle     = 1'b1;
                tick();
                Tx_Complete = 1'b0;
                last_frame  = m_frame;
                if (frame_q.size() > 0) begin
                    m_e = frame_q.pop_front();
                    check("serial_frame", {22'd0, m_frame}, {22'd0, 1'b1, m_e, 1'b0});
                end else begin
                    check("frame_without_issue", 32'd1, 32'd0);
                end
                if (!m_rst_seen) check("tx_data_hold", {31'd0, m_stable}, 32'd1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Monitor: pops the scoreboard on every start pulse
    // ------------------------------------------------------------------
    int         cyc      = 0;
    int         last_cpl = -100;
    logic       prev_en  = 1'b0;
    logic [7:0] mon_e;

    always @(negedge clk) begin
        if (Tx_Enable) begin
            check("enable_one_cycle", {31'd0, prev_en}, 32'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_issue", {24'd0, Tx_Data}, 32'hFFFF_FFFF);
            end else begin
                mon_e = exp_q.pop_front();
                check("tx_data", {24'd0, Tx_Data}, {24'd0, mon_e});
                frame_q.push_back(mon_e);
            end
            check("busy_on_issue", {31'd0, Busy}, 32'd1);
            check("issue_spacing", {31'd0, (cyc - last_cpl) >= 2}, 32'd1);
        end
        if (Tx_Complete) last_cpl = cyc;
        prev_en = Tx_Enable;
        cyc++;
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (caller is always positioned at a falling edge)
    // ------------------------------------------------------------------
    task automatic write_byte(input logic [7:0] d, input bit accept);
        Wr_En   = 1'b1;
        Wr_Data = d;
        if (accept) exp_q.push_back(d);
        @(negedge clk);
        Wr_En   = 1'b0;
    endtask

    task automatic wait_sent(input logic [15:0] n, input int budget);
        int k = 0;
        while (Sent_Count !== n && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("sent_count", {16'd0, Sent_Count}, {16'd0, n});
    endtask

    task automatic wait_model_idle(input int budget);
        int k = 0;
        while (!(tx_idle && !Tx_Complete) && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("tx_model_idle", {31'd0, tx_idle}, 32'd1);
    endtask

    task automatic check_reset_vals();
        check("rst_empty",    {31'd0, Empty},     32'd1);
        check("rst_full",     {31'd0, Full},      32'd0);
        check("rst_level",    {27'd0, Level},     32'd0);
        check("rst_overflow", {31'd0, Overflow},  32'd0);
        check("rst_tx_en",    {31'd0, Tx_Enable}, 32'd0);
        check("rst_tx_data",  {24'd0, Tx_Data},   32'd0);
        check("rst_busy",     {31'd0, Busy},      32'd0);
        check("rst_count",    {16'd0, Sent_Count}, 32'd0);
        check("rst_count_w4", {28'd0, b_count},   32'd0);
    endtask

    task automatic do_reset();
        wait_model_idle(200);
        Reset = 1'b1;
        hold  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        exp_q.delete();
        Reset = 1'b0;
    endtask

    // Global watchdog
    initial begin
        repeat (20000) @(posedge clk);
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Directed scenarios
    // ------------------------------------------------------------------
    initial begin
        Reset   = 1'b1;
        Wr_En   = 1'b0;
        Wr_Data = 8'h00;
        hold    = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals();
        Reset = 1'b0;
        @(negedge clk);

        // Single byte
        write_byte(8'hA5, 1'b1);
        check("single_level_after_write", {27'd0, Level}, 32'd1);
        wait_sent(16'd1, 200);
        check("single_frame", {22'd0, last_frame}, {22'd0, 10'b1101001010});
        check("single_busy_after", {31'd0, Busy}, 32'd0);
        check("single_empty_after", {31'd0, Empty}, 32'd1);

        // Burst of 16 with the transmitter held off
        do_reset();
        hold = 1'b1;
        for (int i = 1; i <= 16; i++) write_byte(8'(i), 1'b1);
        check("burst_full", {31'd0, Full}, 32'd1);
        check("burst_level", {27'd0, Level}, 32'd16);
        check("burst_no_overflow", {31'd0, Overflow}, 32'd0);
        hold = 1'b0;
        wait_sent(16'd16, 2000);
        check("burst_empty", {31'd0, Empty}, 32'd1);

        // Overflow: 17th write dropped, 18th dropped while a pop occurs
        do_reset();
        hold = 1'b1;
        for (int i = 0; i < 16; i++) write_byte(8'h80 + 8'(i), 1'b1);
        write_byte(8'hEE, 1'b0);
        check("ovf_flag", {31'd0, Overflow}, 32'd1);
        check("ovf_level", {27'd0, Level}, 32'd16);
        hold = 1'b0;
        write_byte(8'hEF, 1'b0);
        check("ovf_pop_drop_level", {27'd0, Level}, 32'd15);
        wait_sent(16'd16, 2000);
        repeat (20) @(negedge clk);
        check("ovf_sticky", {31'd0, Overflow}, 32'd1);
        check("ovf_final_count", {16'd0, Sent_Count}, 32'd16);

        // Simultaneous write and pop at Level=3
        do_reset();
        hold = 1'b1;
        write_byte(8'h11, 1'b1);
        write_byte(8'h22, 1'b1);
        write_byte(8'h33, 1'b1);
        check("simul_pre_level", {27'd0, Level}, 32'd3);
        hold = 1'b0;
        write_byte(8'h44, 1'b1);
        check("simul_level", {27'd0, Level}, 32'd3);
        check("simul_issue", {31'd0, Tx_Enable}, 32'd1);
        wait_sent(16'd4, 400);

        // Mid-byte reset
        do_reset();
        write_byte(8'h3C, 1'b1);
        begin
            int k = 0;
            while (!Busy && k < 50) begin
                @(negedge clk);
                k++;
            end
        end
        check("mid_busy", {31'd0, Busy}, 32'd1);
        repeat (10) @(negedge clk);
        Reset = 1'b1;
        @(negedge clk);
        check_reset_vals();
        @(negedge clk);
        Reset = 1'b0;
        wait_model_idle(200);
        repeat (3) @(negedge clk);
        check("mid_stray_count", {16'd0, Sent_Count}, 32'd0);
        write_byte(8'h55, 1'b1);
        wait_sent(16'd1, 200);

        // Counter wrap on the 4-bit instance
        do_reset();
        for (int i = 0; i < 17; i++) write_byte(8'h40 + 8'(i), 1'b1);
        wait_sent(16'd17, 2000);
        check("wrap_count_w4", {28'd0, b_count}, 32'd1);

        wait_model_idle(200);
        repeat (5) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 32'd0);
        check("frames_drained", frame_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
